// File: rtl/adder_share_pkg.sv
// Shared types and widths for the adder-sharing controller.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned OPW       = 8;
    localparam int unsigned SUMW      = 9;
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned SETTLE_W  = 4;
    localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/adder_share_if.sv
// Request, datapath and response signals of the adder-sharing controller.
// ADDER_SHARE_STATS_EN adds the grant counter bus and its clear input.
interface adder_share_if #(
    parameter int unsigned N_REQ = 4
);
    import adder_share_pkg::*;

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*OPW-1:0] req_a;
    logic [N_REQ*OPW-1:0] req_b;
    logic [N_REQ-1:0]     req_ready;
    logic [OPW-1:0]       dp_a;
    logic [OPW-1:0]       dp_b;
    logic [SUMW-1:0]      dp_sum;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [SUMW-1:0]      rsp_sum;
`ifdef ADDER_SHARE_STATS_EN
    logic [N_REQ*CNT_W-1:0] grant_cnt;
    logic                   stats_clr;

    modport slave (
        input  req_valid, req_a, req_b, dp_sum, rsp_ready, stats_clr,
        output req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum, grant_cnt
    );
    modport master (
        output req_valid, req_a, req_b, dp_sum, rsp_ready, stats_clr,
        input  req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum, grant_cnt
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, dp_sum, rsp_ready,
        output req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum
    );
    modport master (
        output req_valid, req_a, req_b, dp_sum, rsp_ready,
        input  req_ready, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum
    );
`endif

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grantIdx,
    output logic                     anyGrant
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    int unsigned     idx;
    logic [ID_W-1:0] sel;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            sel = ID_W'(idx);
            if (!anyGrant && req[sel]) begin
                anyGrant    = 1'b1;
                grantIdx    = sel;
                grant[sel]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one external 8-bit adder between N_REQ round-robin requesters.
// Optional grant statistics are built when ADDER_SHARE_STATS_EN is defined.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    adder_share_if.slave  bus
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    state_t              state;
    state_t              stateNext;
    logic [ID_W-1:0]     rrPtr;
    logic [SETTLE_W-1:0] settleCnt;
    logic [N_REQ-1:0]    grantOh;
    logic [ID_W-1:0]     grantIdx;
    logic                anyGrant;
    logic                accept;
    logic                loadRsp;
    logic                rspDone;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req      (bus.req_valid),
        .ptr      (rrPtr),
        .grant    (grantOh),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Ready is held low while in reset even though it is decoded from state.
    always_comb begin
        stateNext     = state;
        accept        = 1'b0;
        loadRsp       = 1'b0;
        rspDone       = 1'b0;
        bus.req_ready = '0;
        unique case (state)
            IDLE: begin
                if (anyGrant && rst_n) begin
                    bus.req_ready = grantOh;
                    accept        = 1'b1;
                    stateNext     = EXEC;
                end
            end
            EXEC: begin
                if (settleCnt == '0) begin
                    loadRsp   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rspDone   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand, settle and response registers; dp_a/dp_b only move on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr         <= '0;
            settleCnt     <= '0;
            bus.dp_a      <= '0;
            bus.dp_b      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
        end else begin
            if (accept) begin
                bus.dp_a   <= bus.req_a[grantIdx*OPW +: OPW];
                bus.dp_b   <= bus.req_b[grantIdx*OPW +: OPW];
                bus.rsp_id <= grantIdx;
                rrPtr      <= (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
                settleCnt  <= SETTLE_W'(SETTLE - 1);
            end else if (state == EXEC && settleCnt != '0) begin
                settleCnt <= settleCnt - SETTLE_W'(1);
            end
            if (loadRsp) begin
                bus.rsp_sum   <= bus.dp_sum;
                bus.rsp_valid <= 1'b1;
            end else if (rspDone) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_SHARE_STATS_EN
    logic [CNT_W-1:0] grantCnt [N_REQ];

    // Saturating per-requester grant counters; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) grantCnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (bus.stats_clr)
                    grantCnt[i] <= '0;
                else if (accept && grantIdx == ID_W'(i) && grantCnt[i] != '1)
                    grantCnt[i] <= grantCnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.grant_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++)
            bus.grant_cnt[i*CNT_W +: CNT_W] = grantCnt[i];
    end
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: SETTLE=1 instance (A) and SETTLE=4 instance (B).
module tb_adder_share_ctrl;
    import adder_share_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_share_if #(.N_REQ(4)) ifA ();
    adder_share_if #(.N_REQ(4)) ifB ();

    adder_share_ctrl #(.N_REQ(4), .SETTLE(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    adder_share_ctrl #(.N_REQ(4), .SETTLE(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));

    // External adder datapath
    assign ifA.dp_sum = {1'b0, ifA.dp_a} + {1'b0, ifA.dp_b};
    assign ifB.dp_sum = {1'b0, ifB.dp_a} + {1'b0, ifB.dp_b};

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] opA [4];
    logic [8:0] expSum [4];
    logic       got;

    initial begin
        opA    = '{8'hFF, 8'h7F, 8'h33, 8'h01};
        expSum = '{9'h100, 9'h0FF, 9'h100, 9'h001};
        ifA.req_valid = '0; ifA.req_a = '0; ifA.req_b = '0; ifA.rsp_ready = 1'b0;
        ifB.req_valid = '0; ifB.req_a = '0; ifB.req_b = '0; ifB.rsp_ready = 1'b0;
`ifdef ADDER_SHARE_STATS_EN
        ifA.stats_clr = 1'b0;
        ifB.stats_clr = 1'b0;
`endif
        // Reset values while held in reset
        ifA.req_valid = 4'b0001;
        #1;
        chk("rst_ready",  32'(ifA.req_ready), 32'h0);
        chk("rst_rspv",   32'(ifA.rsp_valid), 32'h0);
        chk("rst_dpa",    32'(ifA.dp_a),      32'h0);
        chk("rst_rspsum", 32'(ifA.rsp_sum),   32'h0);
        chk("rst_rspid",  32'(ifA.rsp_id),    32'h0);
        ifA.req_valid = '0;
        doReset();

        // Test 1: reset asserted mid-EXEC (instance B)
        ifB.req_valid = 4'b0010;
        ifB.req_a[15:8] = 8'h5A;
        ifB.req_b[15:8] = 8'hA5;
        #1 chk("t1_ready", 32'(ifB.req_ready), 32'h2);
        @(negedge clk);
        #1 chk("t1_dpa_pre", 32'(ifB.dp_a), 32'h5A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_rspv", 32'(ifB.rsp_valid), 32'h0);
        chk("t1_dpa",  32'(ifB.dp_a),      32'h0);
        chk("t1_dpb",  32'(ifB.dp_b),      32'h0);
        chk("t1_rdy",  32'(ifB.req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t1_idle", 32'(ifB.req_ready), 32'h2);
        ifB.req_valid = '0;

        // Test 2: single op on requester 2, SETTLE=1
        doReset();
        ifA.req_valid = 4'b0100;
        ifA.req_a[23:16] = 8'hFF;
        ifA.req_b[23:16] = 8'h01;
        #1 chk("t2_ready", 32'(ifA.req_ready), 32'h4);
        @(negedge clk);
        ifA.req_valid = '0;
        #1;
        chk("t2_ready_lo", 32'(ifA.req_ready), 32'h0);
        chk("t2_rspv_lo",  32'(ifA.rsp_valid), 32'h0);
        chk("t2_dpa",      32'(ifA.dp_a),      32'hFF);
        chk("t2_dpb",      32'(ifA.dp_b),      32'h01);
        @(negedge clk);
        #1;
        chk("t2_rspv", 32'(ifA.rsp_valid), 32'h1);
        chk("t2_sum",  32'(ifA.rsp_sum),   32'h100);
        chk("t2_id",   32'(ifA.rsp_id),    32'h2);
        ifA.rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk("t2_rspv_done", 32'(ifA.rsp_valid), 32'h0);
        ifA.rsp_ready = 1'b0;

        // Test 3: fairness with all requesters valid
        doReset();
        for (int i = 0; i < 4; i++) begin
            ifA.req_a[i*8 +: 8] = opA[i];
        end
        ifA.req_b = {8'h00, 8'hCD, 8'h80, 8'h01};
        ifA.req_valid = 4'b1111;
        ifA.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_grant", 32'(ifA.req_ready), 32'(1) << (k % 4));
            @(negedge clk);
            #1 chk("t3_gap", 32'(ifA.req_ready), 32'h0);
            @(negedge clk);
            #1;
            chk("t3_rspv", 32'(ifA.rsp_valid), 32'h1);
            chk("t3_id",   32'(ifA.rsp_id),    32'(k % 4));
            chk("t3_sum",  32'(ifA.rsp_sum),   32'(expSum[k % 4]));
            @(negedge clk);
        end
        ifA.req_valid = '0;
        ifA.rsp_ready = 1'b0;

        // Test 4: response backpressure
        doReset();
        ifA.req_valid = 4'b1010;
        #1 chk("t4_grant", 32'(ifA.req_ready), 32'h2);
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t4_rspv",  32'(ifA.rsp_valid), 32'h1);
            chk("t4_id",    32'(ifA.rsp_id),    32'h1);
            chk("t4_sum",   32'(ifA.rsp_sum),   32'h0FF);
            chk("t4_ready", 32'(ifA.req_ready), 32'h0);
            if (j < 4) @(negedge clk);
        end
        ifA.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_rspv_done", 32'(ifA.rsp_valid), 32'h0);
        chk("t4_next",      32'(ifA.req_ready), 32'h8);
        ifA.req_valid = '0;
        ifA.rsp_ready = 1'b0;

        // Test 5: SETTLE=4 latency and 3->0 pointer wrap
        doReset();
        ifB.req_valid = 4'b0100;
        ifB.req_a[23:16] = 8'h80;
        ifB.req_b[23:16] = 8'h80;
        #1 chk("t5_grant", 32'(ifB.req_ready), 32'h4);
        @(negedge clk);
        ifB.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 chk("t5_rspv_early", 32'(ifB.rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("t5_rspv", 32'(ifB.rsp_valid), 32'h1);
        chk("t5_sum",  32'(ifB.rsp_sum),   32'h100);
        chk("t5_id",   32'(ifB.rsp_id),    32'h2);
        ifB.rsp_ready = 1'b1;
        @(negedge clk);
        ifB.req_valid = 4'b1001;
        ifB.req_a[31:24] = 8'h12;
        ifB.req_b[31:24] = 8'h34;
        #1 chk("t5_grant3", 32'(ifB.req_ready), 32'h8);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1 if (ifB.rsp_valid) got = 1'b1;
        end
        chk("t5_timeout", 32'(got), 32'h1);
        chk("t5_id3",  32'(ifB.rsp_id),  32'h3);
        chk("t5_sum3", 32'(ifB.rsp_sum), 32'h046);
        @(negedge clk);
        #1 chk("t5_wrap", 32'(ifB.req_ready), 32'h1);
        ifB.req_valid = '0;
        ifB.rsp_ready = 1'b0;

`ifdef ADDER_SHARE_STATS_EN
        // Test 6: grant counters with clear coincident with a grant
        doReset();
        ifA.req_valid = 4'b0010;
        ifA.rsp_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            #1 chk("t6_grant", 32'(ifA.req_ready), 32'h2);
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            #1 chk("t6_cnt", 32'(ifA.grant_cnt[31:16]), 32'(g + 1));
        end
        #1 chk("t6_grant4", 32'(ifA.req_ready), 32'h2);
        ifA.stats_clr = 1'b1;
        @(negedge clk);
        ifA.stats_clr = 1'b0;
        #1 chk("t6_clr", 32'(ifA.grant_cnt[31:16]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_hold",   32'(ifA.grant_cnt[31:16]), 32'h0);
        chk("t6_grant5", 32'(ifA.req_ready),        32'h2);
        @(negedge clk);
        #1;
        chk("t6_resume", 32'(ifA.grant_cnt[31:16]), 32'h1);
        chk("t6_other",  32'(ifA.grant_cnt[15:0]),  32'h0);
        ifA.req_valid = '0;
        ifA.rsp_ready = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
